regfile_sb: RTL

REGFILE_SB -- requirements
Module: regfile_sb

---
 rtl/regfile_sb.sv | 129 ++++++++++++
 1 files changed

// File: rtl/regfile_sb.sv
// Multi-ported integer register file with an issue scoreboard.
// x0 is hardwired to zero. Optional same-cycle write-to-read forwarding.
module regfile_sb #(
  parameter int unsigned NREG   = 32,
  parameter int unsigned XLEN   = 64,
  parameter int unsigned NRD    = 2,
  parameter int unsigned NWR    = 2,
  parameter int unsigned BYPASS = 1,
  localparam int unsigned AW    = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NRD*AW-1:0]   ra,
  output logic [NRD*XLEN-1:0] rd,
  output logic [NRD-1:0]      rbusy,
  input  logic [NWR-1:0]      wvalid,
  input  logic [NWR*AW-1:0]   wa,
  input  logic [NWR*XLEN-1:0] wd,
  input  logic                alloc_valid,
  input  logic [AW-1:0]       alloc_addr,
  input  logic                flush,
  output logic [NREG-1:0]     busy_vec,
  output logic [AW:0]         busy_cnt
);

  if (NREG < 2 || (NREG & (NREG - 1)) != 0) begin : g_chk_nreg
    $fatal(1, "regfile_sb: NREG must be a power of two and at least 2");
  end
  if (XLEN < 1) begin : g_chk_xlen
    $fatal(1, "regfile_sb: XLEN must be at least 1");
  end
  if (NRD < 1 || NWR < 1) begin : g_chk_ports
    $fatal(1, "regfile_sb: NRD and NWR must be at least 1");
  end
  if (BYPASS > 1) begin : g_chk_bypass
    $fatal(1, "regfile_sb: BYPASS must be 0 or 1");
  end

  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] regs_d [NREG];
  logic [NREG-1:0] busy_q, busy_d;
  logic [AW:0]     cnt_q, cnt_d;

  // Write merge: later ports overwrite earlier ones, so the highest index wins.
  always_comb begin
    logic [AW-1:0] waddr;
    waddr  = '0;
    regs_d = regs_q;
    for (int unsigned j = 0; j < NWR; j++) begin
      waddr = wa[j*AW +: AW];
      if (wvalid[j] && waddr != '0) begin
        regs_d[waddr] = wd[j*XLEN +: XLEN];
      end
    end
  end

  // Scoreboard next state: write clears, then alloc sets (new producer wins), flush clears all.
  always_comb begin
    logic [AW-1:0] waddr;
    waddr  = '0;
    busy_d = busy_q;
    cnt_d  = '0;
    for (int unsigned j = 0; j < NWR; j++) begin
      waddr = wa[j*AW +: AW];
      if (wvalid[j]) begin
        busy_d[waddr] = 1'b0;
      end
    end
    if (alloc_valid && alloc_addr != '0) begin
      busy_d[alloc_addr] = 1'b1;
    end
    if (flush) begin
      busy_d = '0;
    end
    busy_d[0] = 1'b0;
    for (int unsigned r = 0; r < NREG; r++) begin
      cnt_d = cnt_d + (AW+1)'(busy_d[r]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      regs_q <= '{default: '0};
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  // Read ports: stored value, optionally overridden by a matching in-flight write.
  always_comb begin
    logic [AW-1:0]   raddr;
    logic [AW-1:0]   waddr;
    logic [XLEN-1:0] rdata;
    logic            hit;
    raddr = '0;
    waddr = '0;
    rdata = '0;
    hit   = 1'b0;
    rd    = '0;
    rbusy = '0;
    for (int unsigned i = 0; i < NRD; i++) begin
      raddr = ra[i*AW +: AW];
      rdata = regs_q[raddr];
      hit   = 1'b0;
      if (BYPASS != 0) begin
        for (int unsigned j = 0; j < NWR; j++) begin
          waddr = wa[j*AW +: AW];
          if (wvalid[j] && waddr == raddr) begin
            rdata = wd[j*XLEN +: XLEN];
            hit   = 1'b1;
          end
        end
      end
      if (raddr == '0) begin
        rdata = '0;
      end
      rd[i*XLEN +: XLEN] = rdata;
      rbusy[i] = busy_q[raddr] & ~hit & (raddr != '0);
    end
  end

  assign busy_vec = busy_q;
  assign busy_cnt = cnt_q;

endmodule
